pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the IF stage: the successor to the fixed-step PC register. It holds the fetch address, and honours redirects from EX and the pipeline stall vector. It adds a direct-mapped branch target buffer (BTB) that predicts the next fetch address and is trained by resolved branches. It sits between the stall controller / EX stage and the instruction-fetch port.

## Interface
Parameters:
- ADDR_W, 32: fetch address width in bits.
- RESET_PC, 0: address held during reset and fetched first.
- BTB_DEPTH, 16: BTB entries; power of two, at least 2. IDX_W = log2(BTB_DEPTH).

Ports:
- clk_in  in  1  clock; all state changes on the rising edge.
- rst_in  in  1  reset, synchronous, active-low.
- rdy_in  in  1  global ready; when low, all state is frozen.
- stall  in  6  stall vector; only bit 0 (PC stage) is used, 1 = hold.
- redirect_in  in  1  mispredict or jump correction from EX.
- redirect_addr_in  in  ADDR_W  corrected fetch address.
- upd_en_in  in  1  BTB training strobe from EX.
- upd_pc_in  in  ADDR_W  address of the resolved branch.
- upd_target_in  in  ADDR_W  resolved target.
- upd_taken_in  in  1  resolved branch was taken.
- pc_out  out  ADDR_W  current fetch address (registered).
- ce_out  out  1  fetch enable (registered).
- pred_taken_out  out  1  BTB hit for pc_out; the next pc_out is the predicted target.

## Operation
- BTB entry fields: valid, tag, target.
  - tag = pc[ADDR_W-1:IDX_W+2].
  - index = pc[IDX_W+1:2].
  - Bits [1:0] are ignored.
- Lookup is combinational on pc_out. hit = valid[idx] & tag match. pred_taken_out = hit & ce_out.
- next_seq = hit ? target : pc_out + 4. The addition wraps modulo 2^ADDR_W.
- Per-edge priority for pc_out:
  1. Reset (rst_in=0): pc_out=RESET_PC.
  2. rdy_in=0: hold.
  3. ce_out=0: pc_out=RESET_PC.
  4. redirect_in: pc_out=redirect_addr_in. A redirect overrides a stall.
  5. stall[0]=1: hold.
  6. Otherwise: pc_out=next_seq.
- ce_out: reset drives it to 0. It goes to 1 on the first edge with rst_in=1 and rdy_in=1, and stays 1 until the next reset.
- Training happens on an edge with upd_en_in=1, rdy_in=1 and rst_in=1:
  - upd_taken_in=1: write entry[idx(upd_pc_in)] = {valid=1, tag(upd_pc_in), upd_target_in}. Overwrites any prior occupant.
  - upd_taken_in=0: clear valid only if the entry holds a matching tag; otherwise leave it unchanged.
- Training is independent of redirect and stall. Both may take effect on the same edge.

## Timing
- Reset values:
  - pc_out=RESET_PC, ce_out=0, pred_taken_out=0.
  - All BTB valid bits cleared. Tag and target contents are don't-care.
- Reset is honoured regardless of rdy_in.
- Reset release: the first edge with rst_in=1 sets ce_out=1 while pc_out stays RESET_PC. Fetch of RESET_PC occurs in the following cycle.
- Redirect latency: redirect_in sampled at edge N gives pc_out=redirect_addr_in after edge N.
- Training latency: an update at edge N is visible to lookup from cycle N+1. A same-cycle lookup on the same index sees the old entry.
- Reset mid-operation: the next edge restores the reset values, discarding any in-flight update or redirect.

## Configuration
- PC_GEN_BTB_EN defined: BTB is built and behaves as described.
- Not defined:
  - No table storage.
  - pred_taken_out tied to 0.
  - next_seq = pc_out + 4.
  - upd_* inputs are ignored.
  - All other behaviour is identical.

## Test plan
- Reset/startup, RESET_PC=0x100: hold rst_in=0 for 3 cycles, then release -> ce_out=0 and pc_out=0x100 during reset. ce_out=1 after the first released edge. pc_out sequence afterwards is 0x100, 0x104, 0x108.
- Stall vs redirect: stall[0]=1 for 2 cycles at pc 0x20 -> pc_out holds 0x20. Then stall[0]=1 together with redirect_in=1 and redirect_addr_in=0x400 -> pc_out=0x400 next cycle.
- BTB train/hit, BTB_DEPTH=16: update pc=0x40, target 0x80, taken -> when pc_out reaches 0x40, pred_taken_out=1 and the next pc_out is 0x80. A not-taken update at 0x40 then clears the entry, and the next pass goes 0x40 -> 0x44.
- Alias/tag: train 0x40 -> 0x80, then a not-taken update at 0x440 (same index, different tag) -> entry survives and 0x40 still predicts 0x80. A taken update at 0x440 -> 0x900 evicts it, and 0x40 then goes to 0x44.
- Wrap-around and rdy, ADDR_W=32: pc_out=0xFFFFFFFC with no hit -> next pc_out=0x0. With rdy_in=0 for 2 cycles, pc_out and the BTB are unchanged even when upd_en_in=1.
- Build without PC_GEN_BTB_EN: repeat the train/hit scenario -> pred_taken_out stays 0 and the sequence is purely +4.

Source files
------------

// File: rtl/pc_gen.sv
// IF-stage program counter with optional direct-mapped BTB (enable with PC_GEN_BTB_EN).
// pc_out/ce_out registered, 1-cycle redirect; rdy_in low freezes all state, stall[0] holds the PC.
module pc_gen #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              BTB_DEPTH = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [5:0]        stall,
  input  logic              redirect_in,
  input  logic [ADDR_W-1:0] redirect_addr_in,
  input  logic              upd_en_in,
  input  logic [ADDR_W-1:0] upd_pc_in,
  input  logic [ADDR_W-1:0] upd_target_in,
  input  logic              upd_taken_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ce_out,
  output logic              pred_taken_out
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              hit;
  logic [ADDR_W-1:0] pred_target;
  logic [ADDR_W-1:0] next_seq;
  logic              unused_stall;

  assign unused_stall = ^stall[5:1];

`ifdef PC_GEN_BTB_EN
  logic [BTB_DEPTH-1:0] btb_vld;
  logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
  logic [ADDR_W-1:0]    btb_tgt [BTB_DEPTH];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             unused_upd_lsb;

  assign lk_idx         = pc_out[IDX_W+1:2];
  assign lk_tag         = pc_out[ADDR_W-1:IDX_W+2];
  assign up_idx         = upd_pc_in[IDX_W+1:2];
  assign up_tag         = upd_pc_in[ADDR_W-1:IDX_W+2];
  assign unused_upd_lsb = ^upd_pc_in[1:0];

  assign hit         = btb_vld[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign pred_target = btb_tgt[lk_idx];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      btb_vld <= '0;
    end else if (rdy_in && upd_en_in) begin
      if (upd_taken_in) begin
        btb_vld[up_idx] <= 1'b1;
      end else if (btb_tag[up_idx] == up_tag) begin
        // Not-taken only invalidates our own entry; an aliasing branch must not evict it.
        btb_vld[up_idx] <= 1'b0;
      end
    end
  end

  // Tag/target need no reset: they are qualified by btb_vld.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && upd_en_in && upd_taken_in) begin
      btb_tag[up_idx] <= up_tag;
      btb_tgt[up_idx] <= upd_target_in;
    end
  end
`else
  logic unused_upd;

  assign unused_upd  = ^{upd_en_in, upd_pc_in, upd_target_in, upd_taken_in};
  assign hit         = 1'b0;
  assign pred_target = '0;
`endif

  assign pred_taken_out = hit & ce_out;
  assign next_seq       = hit ? pred_target : pc_out + ADDR_W'(4);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pc_out <= RESET_PC;
      ce_out <= 1'b0;
    end else if (rdy_in) begin
      ce_out <= 1'b1;
      if (!ce_out) begin
        pc_out <= RESET_PC;
      end else if (redirect_in) begin
        pc_out <= redirect_addr_in;
      end else if (!stall[0]) begin
        pc_out <= next_seq;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen; expectations adapt to whether PC_GEN_BTB_EN is defined.
module tb_pc_gen;

`ifdef PC_GEN_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  stall;
  logic        redirect_in;
  logic [31:0] redirect_addr_in;
  logic        upd_en_in;
  logic [31:0] upd_pc_in;
  logic [31:0] upd_target_in;
  logic        upd_taken_in;
  logic [31:0] pc_out;
  logic        ce_out;
  logic        pred_taken_out;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        pred;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  pc_gen #(.ADDR_W(32), .RESET_PC(32'h100), .BTB_DEPTH(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall(stall),
    .redirect_in(redirect_in), .redirect_addr_in(redirect_addr_in),
    .upd_en_in(upd_en_in), .upd_pc_in(upd_pc_in), .upd_target_in(upd_target_in),
    .upd_taken_in(upd_taken_in), .pc_out(pc_out), .ce_out(ce_out),
    .pred_taken_out(pred_taken_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic idle_inputs();
    rdy_in      = 1'b1;
    stall       = 6'b0;
    redirect_in = 1'b0;
    upd_en_in   = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_in      = 1'b1;
    redirect_addr_in = a;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    upd_en_in     = 1'b1;
    upd_pc_in     = pc;
    upd_target_in = tgt;
    upd_taken_in  = taken;
  endtask

  // Push the expected post-edge state, clock once, then pop and compare.
  task automatic cyc(input string tag, input logic [31:0] epc, input logic ece, input logic epred);
    exp_t e;
    exp_t g;
    string t;
    e.pc = epc; e.ce = ece; e.pred = epred;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk_in);
    #1;
    g = exp_q.pop_front();
    t = tag_q.pop_front();
    check_val({t, ".pc"}, pc_out, g.pc);
    check_val({t, ".ce"}, {31'b0, ce_out}, {31'b0, g.ce});
    check_val({t, ".pred"}, {31'b0, pred_taken_out}, {31'b0, g.pred});
    idle_inputs();
  endtask

  initial begin
    rst_in = 1'b0;
    redirect_addr_in = '0;
    upd_pc_in = '0; upd_target_in = '0; upd_taken_in = 1'b0;
    idle_inputs();

    // Reset is honoured even with rdy low.
    rdy_in = 1'b0;
    cyc("rst0", 32'h100, 1'b0, 1'b0);
    cyc("rst1", 32'h100, 1'b0, 1'b0);
    cyc("rst2", 32'h100, 1'b0, 1'b0);
    rst_in = 1'b1;
    cyc("rel",  32'h100, 1'b1, 1'b0);
    cyc("seq1", 32'h104, 1'b1, 1'b0);
    cyc("seq2", 32'h108, 1'b1, 1'b0);

    // Stall versus redirect.
    redirect_to(32'h20);          cyc("rd20",  32'h20, 1'b1, 1'b0);
    stall = 6'b000001;            cyc("stl1",  32'h20, 1'b1, 1'b0);
    stall = 6'b111111;            cyc("stl2",  32'h20, 1'b1, 1'b0);
    stall = 6'b000001; redirect_to(32'h400);
                                  cyc("stlrd", 32'h400, 1'b1, 1'b0);
    stall = 6'b111110;            cyc("hiStl", 32'h404, 1'b1, 1'b0);

    // rdy low freezes PC and blocks training.
    rdy_in = 1'b0; train(32'h408, 32'h500, 1'b1); cyc("rdy0a", 32'h404, 1'b1, 1'b0);
    rdy_in = 1'b0; train(32'h408, 32'h500, 1'b1); redirect_to(32'h0);
                                  cyc("rdy0b", 32'h404, 1'b1, 1'b0);
    cyc("rdy1a", 32'h408, 1'b1, 1'b0);
    cyc("rdy1b", 32'h40C, 1'b1, 1'b0);

    // Train 0x40 -> 0x80 on the same edge as a redirect.
    train(32'h40, 32'h80, 1'b1); redirect_to(32'h38);
                                  cyc("tr38",  32'h38, 1'b1, 1'b0);
    cyc("tr3c",  32'h3C, 1'b1, 1'b0);
    cyc("hit40", 32'h40, 1'b1, BTB);
    cyc("tgt",   BTB ? 32'h80 : 32'h44, 1'b1, 1'b0);
    cyc("tgt+4", BTB ? 32'h84 : 32'h48, 1'b1, 1'b0);

    // Not-taken update while sitting on 0x40: this edge still uses the old entry.
    redirect_to(32'h40);          cyc("re40",  32'h40, 1'b1, BTB);
    train(32'h40, 32'h0, 1'b0);   cyc("oldent", BTB ? 32'h80 : 32'h44, 1'b1, 1'b0);
    redirect_to(32'h40);          cyc("clr40", 32'h40, 1'b1, 1'b0);
    cyc("clr44", 32'h44, 1'b1, 1'b0);

    // Alias: same index, different tag.
    train(32'h40, 32'h80, 1'b1);  cyc("al_tr", 32'h48, 1'b1, 1'b0);
    train(32'h440, 32'h0, 1'b0);  cyc("al_nt", 32'h4C, 1'b1, 1'b0);
    redirect_to(32'h40);          cyc("al40",  32'h40, 1'b1, BTB);
    cyc("al_tg", BTB ? 32'h80 : 32'h44, 1'b1, 1'b0);
    train(32'h440, 32'h900, 1'b1); redirect_to(32'h40);
                                  cyc("ev40",  32'h40, 1'b1, 1'b0);
    cyc("ev44",  32'h44, 1'b1, 1'b0);
    redirect_to(32'h440);         cyc("h440",  32'h440, 1'b1, BTB);
    cyc("t900",  BTB ? 32'h900 : 32'h444, 1'b1, 1'b0);

    // Wrap-around.
    redirect_to(32'hFFFF_FFFC);   cyc("wrapA", 32'hFFFF_FFFC, 1'b1, 1'b0);
    cyc("wrapB", 32'h0, 1'b1, 1'b0);
    cyc("wrapC", 32'h4, 1'b1, 1'b0);

    // Reset mid-operation discards redirect/update and clears the BTB.
    rst_in = 1'b0; redirect_to(32'h440); train(32'h100, 32'h200, 1'b1);
                                  cyc("mrst",  32'h100, 1'b0, 1'b0);
    rst_in = 1'b1;                cyc("mrel",  32'h100, 1'b1, 1'b0);
    cyc("m104",  32'h104, 1'b1, 1'b0);
    redirect_to(32'h440);         cyc("m440",  32'h440, 1'b1, 1'b0);
    cyc("m444",  32'h444, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
